// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the Tinker memory arbiter and its neighbours.
package tinker_mem_pkg;

   typedef enum logic {IDLE, WAIT} arb_state_t;
   typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;

   localparam int TINKER_ADDR_W = 32;
   localparam logic [31:0] TINKER_RESET_PC = 32'h0000_2000;

   // Width of a counter that must hold 0..max inclusive.
   function automatic int starve_w(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Request/response and memory-side bundle of the Tinker memory arbiter.
interface tinker_mem_arbiter_if #(parameter int ADDR_W = tinker_mem_pkg::TINKER_ADDR_W);

   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [31:0]       f_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [63:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [63:0]       d_rdata;
   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [63:0]       m_wdata;
   logic [63:0]       m_rdata;
   logic              busy;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata, busy
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata, busy
   );

endinterface

// File: rtl/tinker_arb_pick.sv
// Combinational winner select: data by default, fetch when alone or starved.
module tinker_arb_pick (
   input  logic f_req,
   input  logic d_req,
   input  logic starve,
   output logic f_win,
   output logic d_win
);

   // Winner decode
   always_comb begin
      f_win = f_req & (~d_req | starve);
      d_win = d_req & ~f_win;
   end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Fetch/data arbiter for the single-ported Tinker memory with fixed read latency.
// Optional fetch anti-starvation counter under macro TINKER_ARB_STARVE_EN.
module tinker_mem_arbiter
   import tinker_mem_pkg::*;
#(
   parameter int ADDR_W     = TINKER_ADDR_W,
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic clk,
   input logic reset,
   tinker_mem_arbiter_if.slave bus
);

   localparam logic [2:0] LAT_LOAD = 3'(LATENCY);

   arb_state_t state_r, state_s;
   arb_owner_t owner_r, owner_s;
   logic [2:0] cnt_r, cnt_s;
   logic       f_win_s, d_win_s, starve_s;
   logic       issue_ok_s, f_gnt_s, d_gnt_s, rd_issue_s, capture_s;
   logic       f_rvalid_r, d_rvalid_r;
   logic [31:0] f_rdata_r;
   logic [63:0] d_rdata_r;

   tinker_arb_pick u_pick (
      .f_req  (bus.f_req),
      .d_req  (bus.d_req),
      .starve (starve_s),
      .f_win  (f_win_s),
      .d_win  (d_win_s)
   );

   // Grant path; held off while in reset so every output reads 0
   always_comb begin
      issue_ok_s = reset & (state_r == IDLE);
      f_gnt_s    = issue_ok_s & f_win_s;
      d_gnt_s    = issue_ok_s & d_win_s;
      rd_issue_s = f_gnt_s | (d_gnt_s & ~bus.d_we);
      bus.f_gnt  = f_gnt_s;
      bus.d_gnt  = d_gnt_s;
      bus.m_en   = f_gnt_s | d_gnt_s;
      bus.m_we   = d_gnt_s & bus.d_we;
      if (f_gnt_s) begin
         bus.m_addr  = bus.f_addr;
         bus.m_wdata = 64'd0;
      end else if (d_gnt_s) begin
         bus.m_addr  = bus.d_addr;
         bus.m_wdata = bus.d_wdata;
      end else begin
         bus.m_addr  = '0;
         bus.m_wdata = 64'd0;
      end
   end

   // Next-state, latency counter and read owner
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      owner_s   = owner_r;
      capture_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (rd_issue_s) begin
               state_s = WAIT;
               cnt_s   = LAT_LOAD;
               owner_s = f_gnt_s ? OWN_FETCH : OWN_DATA;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            cnt_s = cnt_r - 3'd1;
            if (cnt_r == 3'd1) begin
               capture_s = 1'b1;
               state_s   = IDLE;
            end else begin
               state_s = WAIT;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 3'd0;
         end
      endcase
   end

   // FSM state, counter and owner registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= 3'd0;
         owner_r <= OWN_FETCH;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         owner_r <= owner_s;
      end
   end

   // Registered read responses to the owning requester
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f_rvalid_r <= 1'b0;
         d_rvalid_r <= 1'b0;
         f_rdata_r  <= 32'd0;
         d_rdata_r  <= 64'd0;
      end else begin
         f_rvalid_r <= capture_s & (owner_r == OWN_FETCH);
         d_rvalid_r <= capture_s & (owner_r == OWN_DATA);
         if (capture_s && owner_r == OWN_FETCH) begin
            f_rdata_r <= bus.m_rdata[31:0];
         end
         if (capture_s && owner_r == OWN_DATA) begin
            d_rdata_r <= bus.m_rdata;
         end
      end
   end

   assign bus.f_rvalid = f_rvalid_r;
   assign bus.d_rvalid = d_rvalid_r;
   assign bus.f_rdata  = f_rdata_r;
   assign bus.d_rdata  = d_rdata_r;
   assign bus.busy     = (state_r == WAIT);

`ifdef TINKER_ARB_STARVE_EN
   localparam int SW = starve_w(STARVE_MAX);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt_r, starve_cnt_s;

   // Count data wins while fetch waits; a fetch grant or idle fetch clears it
   always_comb begin
      starve_cnt_s = starve_cnt_r;
      if (f_gnt_s) begin
         starve_cnt_s = '0;
      end else if (state_r == IDLE && !bus.f_req) begin
         starve_cnt_s = '0;
      end else if (d_gnt_s && bus.f_req && starve_cnt_r != SMAX) begin
         starve_cnt_s = starve_cnt_r + 1'b1;
      end else begin
         starve_cnt_s = starve_cnt_r;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt_r <= '0;
      end else begin
         starve_cnt_r <= starve_cnt_s;
      end
   end

   assign starve_s = (starve_cnt_r == SMAX);
`else
   assign starve_s = 1'b0;
`endif

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Scoreboard bench for tinker_mem_arbiter: directed stimulus, decoupled response monitor.
module tb_tinker_mem_arbiter;

   localparam int LAT = 2;

   typedef struct {
      int          cyc;
      logic [63:0] data;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;
   exp_t f_q[$];
   exp_t d_q[$];
   logic [63:0] pipe [LAT];

   tinker_mem_arbiter_if #(.ADDR_W(32)) bus ();

   tinker_mem_arbiter #(.ADDR_W(32), .LATENCY(LAT), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_2000: return 64'h11223344_AABBCCDD;
         32'h0001_0000: return 64'hCAFEF00D_01234567;
         default:       return {a ^ 32'h5A5A_5A5A, a};
      endcase
   endfunction

   // Memory model: read data appears LAT cycles after the issue cycle
   always @(posedge clk) begin
      pipe[0] <= (bus.m_en && !bus.m_we) ? mem_word(bus.m_addr) : 64'd0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.m_rdata = pipe[LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((f_q.size() != 0 || d_q.size() != 0) && n < 20) begin
         next();
         n++;
      end
      if (f_q.size() != 0 || d_q.size() != 0)
         chk("drain_timeout", 64'(f_q.size() + d_q.size()), 64'd0);
      next();
      next();
   endtask

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            if (bus.f_rvalid) begin
               if (f_q.size() == 0) begin
                  chk("f_rvalid_unexpected", {63'd0, bus.f_rvalid}, 64'd0);
               end else begin
                  e = f_q.pop_front();
                  chk("f_rvalid_cycle", 64'(cyc), 64'(e.cyc));
                  chk("f_rdata", {32'd0, bus.f_rdata}, e.data);
               end
            end
            if (bus.d_rvalid) begin
               if (d_q.size() == 0) begin
                  chk("d_rvalid_unexpected", {63'd0, bus.d_rvalid}, 64'd0);
               end else begin
                  e = d_q.pop_front();
                  chk("d_rvalid_cycle", 64'(cyc), 64'(e.cyc));
                  chk("d_rdata", bus.d_rdata, e.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int t0;
      cyc = 0; checks = 0; failures = 0;
      reset = 1'b0;
      bus.f_req = 1'b1; bus.f_addr = 32'h0000_2000;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0001_0000; bus.d_wdata = 64'd0;

      // Reset state with requests held: nothing may be granted
      next(); next(); sample();
      chk("rst_f_gnt", {63'd0, bus.f_gnt}, 64'd0);
      chk("rst_d_gnt", {63'd0, bus.d_gnt}, 64'd0);
      chk("rst_m_en", {63'd0, bus.m_en}, 64'd0);
      chk("rst_m_addr", {32'd0, bus.m_addr}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_f_rvalid", {63'd0, bus.f_rvalid}, 64'd0);
      chk("rst_d_rvalid", {63'd0, bus.d_rvalid}, 64'd0);
      chk("rst_f_rdata", {32'd0, bus.f_rdata}, 64'd0);
      chk("rst_d_rdata", bus.d_rdata, 64'd0);
      next();
      reset = 1'b1; bus.f_req = 1'b0; bus.d_req = 1'b0;
      next(); next();

      // 1: single fetch read
      next();
      bus.f_req = 1'b1; bus.f_addr = 32'h0000_2000; t0 = cyc;
      sample();
      chk("t1_f_gnt", {63'd0, bus.f_gnt}, 64'd1);
      chk("t1_m_en", {63'd0, bus.m_en}, 64'd1);
      chk("t1_m_we", {63'd0, bus.m_we}, 64'd0);
      chk("t1_m_addr", {32'd0, bus.m_addr}, 64'h2000);
      chk("t1_m_wdata", bus.m_wdata, 64'd0);
      f_q.push_back('{t0 + 3, 64'h0000_0000_AABBCCDD});
      next();
      bus.f_req = 1'b0;
      sample();
      chk("t1_busy", {63'd0, bus.busy}, 64'd1);
      chk("t1_wait_m_en", {63'd0, bus.m_en}, 64'd0);
      drain();

      // 2: simultaneous requests, data wins first
      next();
      bus.f_req = 1'b1; bus.f_addr = 32'h0000_2004;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0001_0000; t0 = cyc;
      sample();
      chk("t2_d_gnt", {63'd0, bus.d_gnt}, 64'd1);
      chk("t2_f_gnt0", {63'd0, bus.f_gnt}, 64'd0);
      chk("t2_m_addr", {32'd0, bus.m_addr}, 64'h1_0000);
      d_q.push_back('{t0 + 3, 64'hCAFEF00D_01234567});
      next();
      bus.d_req = 1'b0;
      sample();
      chk("t2_f_gnt1", {63'd0, bus.f_gnt}, 64'd0);
      next(); sample();
      chk("t2_f_gnt2", {63'd0, bus.f_gnt}, 64'd0);
      next(); sample();
      chk("t2_f_gnt3", {63'd0, bus.f_gnt}, 64'd1);
      chk("t2_m_addr3", {32'd0, bus.m_addr}, 64'h2004);
      f_q.push_back('{t0 + 6, 64'h0000_0000_0000_2004});
      next();
      bus.f_req = 1'b0;
      drain();

      // 3: store held during a fetch wait
      next();
      bus.f_req = 1'b1; bus.f_addr = 32'h0000_2008; t0 = cyc;
      sample();
      chk("t3_f_gnt", {63'd0, bus.f_gnt}, 64'd1);
      f_q.push_back('{t0 + 3, 64'h0000_0000_0000_2008});
      next();
      bus.f_req = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0001_0008; bus.d_wdata = 64'h55;
      sample();
      chk("t3_d_gnt_w1", {63'd0, bus.d_gnt}, 64'd0);
      chk("t3_m_en_w1", {63'd0, bus.m_en}, 64'd0);
      next(); sample();
      chk("t3_d_gnt_w2", {63'd0, bus.d_gnt}, 64'd0);
      next(); sample();
      chk("t3_d_gnt", {63'd0, bus.d_gnt}, 64'd1);
      chk("t3_m_we", {63'd0, bus.m_we}, 64'd1);
      chk("t3_m_wdata", bus.m_wdata, 64'h55);
      chk("t3_m_addr", {32'd0, bus.m_addr}, 64'h1_0008);
      next();
      bus.d_req = 1'b0;
      sample();
      chk("t3_busy_after_store", {63'd0, bus.busy}, 64'd0);
      drain();

      // 6: withdrawal of a data request during a fetch wait
      next();
      bus.f_req = 1'b1; bus.f_addr = 32'h0000_2010; t0 = cyc;
      sample();
      chk("t6_f_gnt", {63'd0, bus.f_gnt}, 64'd1);
      f_q.push_back('{t0 + 3, 64'h0000_0000_0000_2010});
      next();
      bus.f_req = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0001_0030;
      sample();
      chk("t6_d_gnt_w1", {63'd0, bus.d_gnt}, 64'd0);
      next();
      bus.d_req = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'h0000_2014;
      sample();
      chk("t6_d_gnt_w2", {63'd0, bus.d_gnt}, 64'd0);
      next(); sample();
      chk("t6_f_gnt_next", {63'd0, bus.f_gnt}, 64'd1);
      chk("t6_d_gnt_next", {63'd0, bus.d_gnt}, 64'd0);
      chk("t6_m_addr", {32'd0, bus.m_addr}, 64'h2014);
      f_q.push_back('{t0 + 6, 64'h0000_0000_0000_2014});
      next();
      bus.f_req = 1'b0;
      drain();

      // 4: starvation with stores held continuously
`ifdef TINKER_ARB_STARVE_EN
      for (int r = 0; r < 2; r++) begin
         next();
         bus.f_req = 1'b1; bus.f_addr = 32'h0000_200C;
         bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0001_0010;
         for (int i = 0; i < 5; i++) begin
            bus.d_wdata = 64'(i + 1);
            sample();
            if (i < 4) begin
               chk("t4_d_gnt", {63'd0, bus.d_gnt}, 64'd1);
               chk("t4_f_gnt0", {63'd0, bus.f_gnt}, 64'd0);
               chk("t4_m_wdata", bus.m_wdata, 64'(i + 1));
            end else begin
               chk("t4_f_gnt", {63'd0, bus.f_gnt}, 64'd1);
               chk("t4_d_gnt0", {63'd0, bus.d_gnt}, 64'd0);
               chk("t4_m_we0", {63'd0, bus.m_we}, 64'd0);
               f_q.push_back('{cyc + 3, 64'h0000_0000_0000_200C});
            end
            next();
         end
         bus.f_req = 1'b0; bus.d_req = 1'b0;
         drain();
      end
`else
      next();
      bus.f_req = 1'b1; bus.f_addr = 32'h0000_200C;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0001_0010;
      for (int i = 0; i < 8; i++) begin
         bus.d_wdata = 64'(i + 1);
         sample();
         chk("t4_d_gnt", {63'd0, bus.d_gnt}, 64'd1);
         chk("t4_f_gnt_never", {63'd0, bus.f_gnt}, 64'd0);
         chk("t4_m_wdata", bus.m_wdata, 64'(i + 1));
         next();
      end
      bus.d_req = 1'b0;
      sample();
      chk("t4_f_gnt_alone", {63'd0, bus.f_gnt}, 64'd1);
      f_q.push_back('{cyc + 3, 64'h0000_0000_0000_200C});
      next();
      bus.f_req = 1'b0;
      drain();
`endif

      // 5: reset in the middle of a load
      next();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0001_0020;
      sample();
      chk("t5_d_gnt", {63'd0, bus.d_gnt}, 64'd1);
      next();
      bus.d_req = 1'b0; bus.f_req = 1'b1; reset = 1'b0;
      #1;
      chk("t5_busy", {63'd0, bus.busy}, 64'd0);
      chk("t5_f_gnt", {63'd0, bus.f_gnt}, 64'd0);
      chk("t5_m_en", {63'd0, bus.m_en}, 64'd0);
      chk("t5_d_rvalid", {63'd0, bus.d_rvalid}, 64'd0);
      chk("t5_d_rdata", bus.d_rdata, 64'd0);
      chk("t5_f_rdata", {32'd0, bus.f_rdata}, 64'd0);
      next();
      reset = 1'b1; bus.f_req = 1'b0;
      repeat (6) next();
      sample();
      chk("t5_busy_after", {63'd0, bus.busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tinker_mem_arbiter.md
# tinker_mem_arbiter

- Shares the single-ported Tinker byte memory between the instruction-fetch path and the load/store path. Those two requesters are the core's PC fetch and the data access side (LD/ST/CALL/RETURN).
- Arbitrates between them, issues one memory access at a time, and times the fixed read latency.
- Returns read data with a one-cycle valid pulse to the requester that issued the read.
- Sits between `tinker_core` and the `memory` instance; replaces the core's two separate memory instances.

## Interface
- `ADDR_W`, 32: address width, byte address.
- `LATENCY`, 2: cycles from issue to `m_rdata` valid. Legal range 1..7.
- `STARVE_MAX`, 4: number of consecutive data grants, while fetch is waiting, before fetch is forced a win.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low (asserted when 0).
- `f_req`  in  1  fetch request; held with `f_addr` until `f_gnt`.
- `f_addr`  in  ADDR_W  fetch address.
- `f_gnt`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  one-cycle pulse: `f_rdata` is valid.
- `f_rdata`  out  32  instruction word, `m_rdata[31:0]`; held until the next fetch response.
- `d_req`  in  1  data request; held with the fields below until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  64  store data.
- `d_gnt`  out  1  data request accepted this cycle; for a store, this is also completion.
- `d_rvalid`  out  1  one-cycle load-data pulse.
- `d_rdata`  out  64  load data; held until the next load response.
- `m_en`  out  1  memory access strobe.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  ADDR_W  memory address.
- `m_wdata`  out  64  memory write data.
- `m_rdata`  in  64  memory read data, little-endian, valid `LATENCY` cycles after issue.
- `busy`  out  1  a read is outstanding (state is not IDLE).

## Operation
- **States:**
  - IDLE: free to issue.
  - WAIT: a read is outstanding; the latency counter runs.
- **Arbitration in IDLE:**
  - Runs combinationally on `f_req`/`d_req`.
  - Default winner is data.
  - Fetch wins if only `f_req` is asserted, or if the starvation count equals `STARVE_MAX`.
- **Issue cycle (winner's `gnt`=1):**
  - `m_en`=1; `m_addr`, `m_we` and `m_wdata` come from the winner.
  - Fetch forces `m_we`=0 and `m_wdata`=0.
- **Store issue:** the write completes in the issue cycle; the block stays in IDLE and gives no rvalid.
- **Read issue:** go to WAIT, load counter = `LATENCY`, record the owner (fetch/data).
- **WAIT:**
  - Counter decrements each cycle.
  - In the cycle the counter reads 1, capture `m_rdata` into the owner's rdata register.
  - Next cycle: owner's rvalid = 1 and state returns to IDLE.
  - A new grant is allowed in that same cycle.
- **During WAIT:** `f_gnt`=`d_gnt`=`m_en`=0; requests wait.
- **Withdrawal:** a requester may drop `req` before `gnt`, with no side effect.
- **Starvation count:**
  - Increments on each data grant made while `f_req`=1.
  - Clears on a fetch grant, and when `f_req`=0 in IDLE.
  - Saturates at `STARVE_MAX`.
- **Reset (any time, including mid-read):**
  - State goes to IDLE, counter to 0, owner to fetch, starvation count to 0.
  - All outputs go to 0, including both rdata registers.
  - The pending read is dropped and never gives an rvalid.

## Timing
- **Read:** issue in cycle T; `m_rdata` is sampled at the end of T+`LATENCY`; rvalid is high in T+`LATENCY`+1.
- **Throughput:**
  - Back-to-back reads: one every `LATENCY`+1 cycles.
  - Back-to-back stores: one per cycle.
- **Grant path:** `gnt`/`m_*` are combinational from `req` and state; no other combinational input-to-output paths.
- **Response outputs:** rvalid/rdata/`busy` are registered.

## Configuration
- Macro `TINKER_ARB_STARVE_EN`.
- Defined: starvation counter present; fetch is forced a grant after `STARVE_MAX` consecutive data wins while it waits.
- Undefined: strict data priority; no counter is built and `STARVE_MAX` is ignored.

## Structure
- `tinker_mem_pkg` holds:
  - `arb_state_t` {IDLE, WAIT};
  - `arb_owner_t` {OWN_FETCH, OWN_DATA};
  - `ADDR_W` default;
  - `TINKER_RESET_PC` (32'h2000) for shared use.
- One sub-module, `tinker_arb_pick`: combinational winner select from `f_req`, `d_req` and the starvation flag.

## Test plan
1. **Single fetch read:**
   - Stimulus: `LATENCY`=2; `f_req` with `f_addr`=0x2000 in cycle 0; `m_rdata`=0x11223344_AABBCCDD in cycle 2.
   - Required: `f_gnt` in cycle 0; `f_rvalid` in cycle 3; `f_rdata`=0xAABBCCDD.
2. **Simultaneous requests:**
   - Stimulus: `f_req` and `d_req` (load, 0x10000) in cycle 0.
   - Required: `d_gnt` in cycle 0; `f_gnt` in cycle 3; `d_rvalid` in cycle 3.
3. **Store during fetch wait:**
   - Stimulus: store 0x55 to 0x10008 held while a fetch read is outstanding.
   - Required: `d_gnt`=0 during WAIT; `m_we`=1 with `m_wdata`=0x55 in the return-to-IDLE cycle; no `d_rvalid`.
4. **Starvation (`TINKER_ARB_STARVE_EN`, `STARVE_MAX`=4):**
   - Stimulus: `d_req` stores held continuously with `f_req` held.
   - Required: four `d_gnt`s, then `f_gnt`; count returns to 0.
   - Without the macro: `f_gnt` never asserts.
5. **Reset mid-read:**
   - Stimulus: `reset`=0 in cycle 1 of a `LATENCY`=3 load.
   - Required: `busy`=0 and all outputs 0 immediately; no `d_rvalid` after release.
6. **Withdrawal:**
   - Stimulus: `d_req` dropped while a read is outstanding.
   - Required: no `d_gnt`; `f_req` alone is granted next in IDLE.
